// File: rtl/ppu_vram_port.sv
// CPU-side VRAM access port: $2000 increment bit, $2002 toggle clear, $2006 address
// register and $2007 data port with a one-deep delayed-read buffer.
module ppu_vram_port #(
  parameter int VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         ri_sel,
  input  logic               ri_ncs,
  input  logic               ri_r_nw,
  input  logic [7:0]         ri_din,
  output logic [7:0]         ri_dout,
  output logic [VRAM_AW-1:0] vram_a,
  output logic               vram_wr,
  output logic [7:0]         vram_dout,
  input  logic [7:0]         vram_din,
  output logic               ovr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RD_CAP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [VRAM_AW-1:0] v_q, v_d;
  logic [VRAM_AW-9:0] t_q, t_d;
  logic               toggle_q, toggle_d;
  logic               inc32_q, inc32_d;
  logic [7:0]         rd_buf_q, rd_buf_d;
  logic [7:0]         ri_dout_q, ri_dout_d;
  logic               vram_wr_q, vram_wr_d;
  logic [7:0]         vram_dout_q, vram_dout_d;
  logic               ovr_q, ovr_d;
  logic               ncs_q;
  logic               start;
  logic [VRAM_AW-1:0] v_inc;

  assign start = ncs_q & ~ri_ncs;
  assign v_inc = v_q + (inc32_q ? VRAM_AW'(32) : VRAM_AW'(1));

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    t_d         = t_q;
    toggle_d    = toggle_q;
    inc32_d     = inc32_q;
    rd_buf_d    = rd_buf_q;
    ri_dout_d   = ri_dout_q;
    vram_wr_d   = 1'b0;
    vram_dout_d = vram_dout_q;
    ovr_d       = start && (state_q != S_IDLE);
    case (state_q)
      S_WR: begin
        v_d     = v_inc;
        state_d = S_IDLE;
      end
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rd_buf_d = vram_din;
        v_d      = v_inc;
        state_d  = S_IDLE;
      end
      default: begin
        // Only an idle port accepts accesses, so v has a single writer per cycle.
        if (start) begin
          case (ri_sel)
            3'd0: if (!ri_r_nw) inc32_d = ri_din[2];
            3'd2: if (ri_r_nw) begin
              toggle_d  = 1'b0;
              ri_dout_d = 8'h00;
            end
            3'd6: if (!ri_r_nw) begin
              if (toggle_q) begin
                v_d      = VRAM_AW'({t_q, ri_din});
                toggle_d = 1'b0;
              end else begin
                t_d      = (VRAM_AW-8)'(ri_din[5:0]);
                toggle_d = 1'b1;
              end
            end
            3'd7: begin
              if (ri_r_nw) begin
                ri_dout_d = rd_buf_q;
                state_d   = S_RD_WAIT;
              end else begin
                vram_wr_d   = 1'b1;
                vram_dout_d = ri_din;
                state_d     = S_WR;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      v_q         <= '0;
      t_q         <= '0;
      toggle_q    <= 1'b0;
      inc32_q     <= 1'b0;
      rd_buf_q    <= '0;
      ri_dout_q   <= '0;
      vram_wr_q   <= 1'b0;
      vram_dout_q <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      t_q         <= t_d;
      toggle_q    <= toggle_d;
      inc32_q     <= inc32_d;
      rd_buf_q    <= rd_buf_d;
      ri_dout_q   <= ri_dout_d;
      vram_wr_q   <= vram_wr_d;
      vram_dout_q <= vram_dout_d;
      ovr_q       <= ovr_d;
    end
  end

  // Edge detector tracks the bus through reset so a held-low select is not seen as new.
  always_ff @(posedge clk) ncs_q <= ri_ncs;

  assign ri_dout   = ri_dout_q;
  assign vram_a    = v_q;
  assign vram_wr   = vram_wr_q;
  assign vram_dout = vram_dout_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed plus random register accesses against a register-level model of the port.
module tb_ppu_vram_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ri_sel = '0;
  logic        ri_ncs = 1'b1;
  logic        ri_r_nw = 1'b1;
  logic [7:0]  ri_din = '0;
  logic [7:0]  ri_dout;
  logic [13:0] vram_a;
  logic        vram_wr;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din = '0;
  logic        ovr;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] mem   [16384];
  logic [7:0] mem_m [16384];

  int m_v, m_t, m_toggle, m_inc32, m_rdbuf, m_dout;

  ppu_vram_port #(.VRAM_AW(14)) dut (
    .clk(clk), .rst(rst), .ri_sel(ri_sel), .ri_ncs(ri_ncs), .ri_r_nw(ri_r_nw),
    .ri_din(ri_din), .ri_dout(ri_dout), .vram_a(vram_a), .vram_wr(vram_wr),
    .vram_dout(vram_dout), .vram_din(vram_din), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Memory controller: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (vram_wr) mem[vram_a] <= vram_dout;
    vram_din <= mem[vram_a];
  end

  always @(negedge clk) if (vram_wr) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_t = 0; m_toggle = 0; m_inc32 = 0; m_rdbuf = 0; m_dout = 0;
  endtask

  task automatic access(input logic [2:0] sel, input logic rnw, input logic [7:0] din);
    int old_v, old_dout, old_rdbuf, exp_a1, exp_dout1, wr0, hold;
    bit wr7, rd7;
    old_v = m_v; old_dout = m_dout; old_rdbuf = m_rdbuf;
    wr7 = (sel == 3'd7) && !rnw;
    rd7 = (sel == 3'd7) && rnw;
    exp_dout1 = old_dout;
    if (sel == 3'd0 && !rnw) m_inc32 = din[2];
    if (sel == 3'd2 && rnw) begin m_toggle = 0; m_dout = 0; exp_dout1 = 0; end
    if (sel == 3'd6 && !rnw) begin
      if (m_toggle != 0) begin m_v = m_t * 256 + din; m_toggle = 0; end
      else begin m_t = din % 64; m_toggle = 1; end
    end
    exp_a1 = m_v;
    if (wr7) begin
      mem_m[m_v] = din;
      m_v = (m_v + (m_inc32 != 0 ? 32 : 1)) % 16384;
    end
    if (rd7) begin
      m_dout = old_rdbuf; exp_dout1 = old_rdbuf;
      m_rdbuf = mem_m[m_v];
      m_v = (m_v + (m_inc32 != 0 ? 32 : 1)) % 16384;
    end
    wr0 = wr_cnt;
    hold = $urandom_range(1, 3);
    @(negedge clk);
    ri_sel = sel; ri_r_nw = rnw; ri_din = din; ri_ncs = 1'b0;
    @(posedge clk); #1;
    check("a_n1", vram_a, exp_a1);
    check("ovr_n1", ovr, 0);
    check("wr_n1", vram_wr, wr7);
    check("dout_n1", ri_dout, exp_dout1);
    if (wr7) check("wdata_n1", vram_dout, din);
    repeat (hold) @(negedge clk);
    ri_ncs = 1'b1;
    repeat (4) @(negedge clk);
    check("a_end", vram_a, m_v);
    check("dout_end", ri_dout, m_dout);
    check("wr_pulses", wr_cnt - wr0, wr7 ? 1 : 0);
  endtask

  initial begin
    int v0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 8'($urandom);
      mem_m[i] = mem[i];
    end
    mem[16'h10] = 8'h11; mem_m[16'h10] = 8'h11;
    mem[16'h11] = 8'h22; mem_m[16'h11] = 8'h22;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dout", ri_dout, 0);
    check("rst_a", vram_a, 0);
    check("rst_wr", vram_wr, 0);
    check("rst_wdata", vram_dout, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;

    // Address load and two writes
    access(3'd6, 1'b0, 8'h21);
    access(3'd6, 1'b0, 8'h08);
    check("addr_2108", vram_a, 14'h2108);
    access(3'd0, 1'b0, 8'h00);
    access(3'd7, 1'b0, 8'hAA);
    access(3'd7, 1'b0, 8'h55);
    check("addr_210a", vram_a, 14'h210A);

    // Delayed reads
    access(3'd6, 1'b0, 8'h00);
    access(3'd6, 1'b0, 8'h10);
    access(3'd7, 1'b1, 8'h00);
    check("rd0", ri_dout, 8'h00);
    access(3'd7, 1'b1, 8'h00);
    check("rd1", ri_dout, 8'h11);
    access(3'd7, 1'b1, 8'h00);
    check("rd2", ri_dout, 8'h22);
    check("addr_0013", vram_a, 14'h0013);

    // +32 wrap
    access(3'd0, 1'b0, 8'h04);
    access(3'd6, 1'b0, 8'h3F);
    access(3'd6, 1'b0, 8'hF0);
    access(3'd7, 1'b0, 8'h77);
    check("wrap32", vram_a, 14'h0010);
    check("wrap_mem", mem[14'h3FF0], 8'h77);

    // $2002 read clears the toggle
    access(3'd0, 1'b0, 8'h00);
    access(3'd6, 1'b0, 8'h3F);
    access(3'd2, 1'b1, 8'h00);
    access(3'd6, 1'b0, 8'h12);
    access(3'd6, 1'b0, 8'h34);
    check("addr_1234", vram_a, 14'h1234);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [2:0] s;
      logic [7:0] d;
      s = 3'($urandom);
      d = 8'($urandom);
      access(s, 1'($urandom), d);
    end

    // Collision: write starts two cycles after a read
    v0 = wr_cnt;
    @(negedge clk);
    ri_sel = 3'd7; ri_r_nw = 1'b1; ri_ncs = 1'b0;
    m_dout = m_rdbuf; m_rdbuf = mem_m[m_v];
    m_v = (m_v + (m_inc32 != 0 ? 32 : 1)) % 16384;
    @(negedge clk); ri_ncs = 1'b1;
    @(negedge clk); ri_sel = 3'd7; ri_r_nw = 1'b0; ri_din = 8'h5A; ri_ncs = 1'b0;
    @(posedge clk); #1;
    check("ovr_pulse", ovr, 1);
    check("ovr_no_wr", vram_wr, 0);
    check("ovr_rd_done", vram_a, m_v);
    @(negedge clk); ri_ncs = 1'b1;
    @(posedge clk); #1;
    check("ovr_once", ovr, 0);
    repeat (4) @(negedge clk);
    check("ovr_wr_cnt", wr_cnt - v0, 0);
    check("ovr_dout", ri_dout, m_dout);
    access(3'd7, 1'b1, 8'h00);

    // Reset during RD_WAIT
    @(negedge clk);
    ri_sel = 3'd7; ri_r_nw = 1'b1; ri_ncs = 1'b0;
    @(negedge clk); rst = 1'b1; ri_ncs = 1'b1;
    @(negedge clk);
    check("rrst_dout", ri_dout, 0);
    check("rrst_a", vram_a, 0);
    check("rrst_wr", vram_wr, 0);
    check("rrst_wdata", vram_dout, 0);
    check("rrst_ovr", ovr, 0);
    rst = 1'b0;
    model_reset();
    access(3'd7, 1'b1, 8'h00);
    access(3'd7, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
